// File: rtl/mac_seq_if.sv
// mac_seq_if: CFU command/response port between the CPU and mac_seq_ctrl.
interface mac_seq_if #(
   parameter int unsigned ACC_W = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [9:0]       cmd_payload_function_id;
   logic [31:0]      cmd_payload_inputs_0;
   logic [31:0]      cmd_payload_inputs_1;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [ACC_W-1:0] rsp_payload_outputs_0;

   // CPU side issues commands and takes responses
   modport master (
      output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
             cmd_payload_inputs_1, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_payload_outputs_0
   );

   // Controller side accepts commands and returns responses
   modport slave (
      input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
             cmd_payload_inputs_1, rsp_ready,
      output cmd_ready, rsp_valid, rsp_payload_outputs_0
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencing controller for the 4-lane int8 SIMD MAC CFU.
// Filter words are loaded into a local buffer, each RUN multiplies one input
// word against the next filter word (MUL stage) and accumulates (ACC stage);
// the finished dot product is returned after N RUNs.
// Optional feature macro: MAC_SEQ_STATUS_EN enables the STATUS opcode and
// the LOAD overflow flag.
module mac_seq_ctrl #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned ACC_W = 32
) (
   input  logic     clk,
   input  logic     reset_n,
   mac_seq_if.slave bus
);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW    = 5;
   localparam int unsigned LANES = 4;

   localparam logic [6:0] OP_CFG    = 7'd0;
   localparam logic [6:0] OP_LOAD   = 7'd1;
   localparam logic [6:0] OP_RUN    = 7'd2;
`ifdef MAC_SEQ_STATUS_EN
   localparam logic [6:0] OP_STATUS = 7'd3;
`endif

   typedef enum logic [1:0] {IDLE, MUL, ACC, RSP} state_t;

   state_t                  state;
   logic                    cmd_ready_q;
   logic                    rsp_valid_q;
   logic [ACC_W-1:0]        rsp_data_q;
   logic [ACC_W-1:0]        acc_q;
   logic signed [8:0]       offset_q;
   logic [PW-1:0]           n_q;
   logic [PW-1:0]           wr_ptr_q;
   logic [PW-1:0]           rd_ptr_q;
   logic [31:0]             in_q;
   logic signed [17:0]      prod_q [LANES];
   logic [31:0]             fbuf [DEPTH];
`ifdef MAC_SEQ_STATUS_EN
   logic                    overflow_q;
   logic [ACC_W-1:0]        status_c;
`endif

   logic                    accept_c;
   logic                    wr_room_c;
   logic                    load_we_c;
   logic                    last_c;
   logic [6:0]              op_c;
   logic [PW-1:0]           n_cfg_c;
   logic [PW-1:0]           wr_next_c;
   logic [PW-1:0]           rd_next_c;
   logic [31:0]             rd_word_c;
   logic signed [9:0]       opnd_c [LANES];
   logic signed [7:0]       wgt_c [LANES];
   logic signed [17:0]      prod_c [LANES];
   logic signed [ACC_W-1:0] sum_c;
   logic [ACC_W-1:0]        acc_next_c;
   logic                    unused_bits;

   assign bus.cmd_ready             = cmd_ready_q;
   assign bus.rsp_valid             = rsp_valid_q;
   assign bus.rsp_payload_outputs_0 = rsp_data_q;

   // Low function_id bits and high N bits carry no meaning
   assign unused_bits = ^{bus.cmd_payload_function_id[2:0],
                          bus.cmd_payload_inputs_1[31:PW]};

   // Command decode, pointer arithmetic, lane products and lane sum
   always_comb begin
      op_c      = bus.cmd_payload_function_id[9:3];
      accept_c  = bus.cmd_valid && cmd_ready_q && (state == IDLE);
      wr_room_c = (wr_ptr_q < PW'(DEPTH));
      load_we_c = accept_c && (op_c == OP_LOAD) && wr_room_c;
      wr_next_c = wr_room_c ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_next_c = rd_ptr_q + PW'(1);
      last_c    = (rd_next_c == n_q);

      // N of 0 or beyond the buffer means "whole buffer"
      if ((bus.cmd_payload_inputs_1[PW-1:0] == '0) ||
          (32'(bus.cmd_payload_inputs_1[PW-1:0]) > DEPTH))
         n_cfg_c = PW'(DEPTH);
      else
         n_cfg_c = bus.cmd_payload_inputs_1[PW-1:0];

      rd_word_c = fbuf[rd_ptr_q[AW-1:0]];
      sum_c     = '0;
      for (int i = 0; i < LANES; i++) begin
         opnd_c[i] = 10'(signed'(in_q[8*i +: 8])) + 10'(offset_q);
         wgt_c[i]  = signed'(rd_word_c[8*i +: 8]);
         prod_c[i] = 18'(opnd_c[i]) * 18'(wgt_c[i]);
         sum_c     = sum_c + ACC_W'(prod_q[i]);
      end
      acc_next_c = acc_q + $unsigned(sum_c);

`ifdef MAC_SEQ_STATUS_EN
      status_c = ACC_W'({overflow_q, (wr_ptr_q < n_q), 9'b0, n_q,
                         3'b0, wr_ptr_q, 3'b0, rd_ptr_q});
`endif
   end

   // Filter buffer write port; contents deliberately left unreset
   always_ff @(posedge clk) begin
      if (load_we_c)
         fbuf[wr_ptr_q[AW-1:0]] <= bus.cmd_payload_inputs_0;
   end

   // Sequencing FSM with registered handshake, response and datapath state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         acc_q       <= '0;
         offset_q    <= 9'sd128;
         n_q         <= PW'(DEPTH);
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         in_q        <= '0;
         prod_q      <= '{default: '0};
`ifdef MAC_SEQ_STATUS_EN
         overflow_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  cmd_ready_q <= 1'b0;
                  if (op_c == OP_RUN) begin
                     in_q  <= bus.cmd_payload_inputs_0;
                     state <= MUL;
                  end else begin
                     state       <= RSP;
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '0;
                     case (op_c)
                        OP_CFG: begin
                           offset_q   <= signed'(bus.cmd_payload_inputs_0[8:0]);
                           n_q        <= n_cfg_c;
                           wr_ptr_q   <= '0;
                           rd_ptr_q   <= '0;
                           acc_q      <= '0;
`ifdef MAC_SEQ_STATUS_EN
                           overflow_q <= 1'b0;
`endif
                        end
                        OP_LOAD: begin
                           wr_ptr_q   <= wr_next_c;
                           rsp_data_q <= ACC_W'(wr_next_c);
`ifdef MAC_SEQ_STATUS_EN
                           if (!wr_room_c)
                              overflow_q <= 1'b1;
`endif
                        end
`ifdef MAC_SEQ_STATUS_EN
                        OP_STATUS: rsp_data_q <= status_c;
`endif
                        default: ;
                     endcase
                  end
               end
            end
            MUL: begin
               prod_q <= prod_c;
               state  <= ACC;
            end
            ACC: begin
               rsp_data_q  <= acc_next_c;
               rsp_valid_q <= 1'b1;
               state       <= RSP;
               if (last_c) begin
                  acc_q    <= '0;
                  rd_ptr_q <= '0;
               end else begin
                  acc_q    <= acc_next_c;
                  rd_ptr_q <= rd_next_c;
               end
            end
            RSP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed plus randomized bench for mac_seq_ctrl against a
// behavioural dot-product model.
module tb_mac_seq_ctrl;
   localparam int DEPTH = 16;
   localparam logic [6:0] OP_CFG  = 7'd0;
   localparam logic [6:0] OP_LOAD = 7'd1;
   localparam logic [6:0] OP_RUN  = 7'd2;
   localparam logic [6:0] OP_STAT = 7'd3;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   // behavioural model state
   logic [31:0] m_buf [DEPTH];
   bit          m_vld [DEPTH];
   int          m_off, m_n, m_wr, m_rd, m_acc;
   bit          m_ovf;

   mac_seq_if #(.ACC_W(32)) bus ();

   mac_seq_ctrl #(.DEPTH(DEPTH), .ACC_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_off = 128; m_n = DEPTH; m_wr = 0; m_rd = 0; m_acc = 0; m_ovf = 0;
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
   endtask

   // Expected response for one command, advancing the model state
   function automatic logic [31:0] model_cmd(input logic [6:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [7:0] x, w;
      int dot, r;
      case (op)
         OP_CFG: begin
            m_off = int'($signed(a[8:0]));
            m_n   = int'(b[4:0]);
            if (m_n == 0 || m_n > DEPTH) m_n = DEPTH;
            m_wr = 0; m_rd = 0; m_acc = 0; m_ovf = 0;
            return 32'd0;
         end
         OP_LOAD: begin
            if (m_wr < DEPTH) begin
               m_buf[m_wr] = a; m_vld[m_wr] = 1; m_wr++;
            end else m_ovf = 1;
            return 32'(m_wr);
         end
         OP_RUN: begin
            if (!m_vld[m_rd]) $display("note: bench ran over an unloaded entry");
            dot = 0;
            for (int i = 0; i < 4; i++) begin
               x = a[8*i +: 8];
               w = m_buf[m_rd][8*i +: 8];
               dot += (int'(x) + m_off) * int'(w);
            end
            m_acc += dot;
            m_rd++;
            r = m_acc;
            if (m_rd == m_n) begin m_acc = 0; m_rd = 0; end
            return 32'(r);
         end
`ifdef MAC_SEQ_STATUS_EN
         OP_STAT: return {m_ovf, (m_wr < m_n), 9'b0, 5'(m_n), 3'b0, 5'(m_wr), 3'b0, 5'(m_rd)};
`endif
         default: return 32'd0;
      endcase
   endfunction

   // Issue one command and complete its response handshake
   task automatic run_cmd(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit early, input int stall,
                          output logic [31:0] data, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid               = 1'b1;
      bus.cmd_payload_function_id = {op, 3'($urandom)};
      bus.cmd_payload_inputs_0    = a;
      bus.cmd_payload_inputs_1    = b;
      bus.rsp_ready               = early;
      @(posedge clk); #1;
      bus.cmd_valid            = 1'b0;
      bus.cmd_payload_inputs_0 = $urandom;
      bus.cmd_payload_inputs_1 = $urandom;
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
      data = bus.rsp_payload_outputs_0;
      if (!early) begin
         for (int k = 0; k < stall; k++) begin
            if (k == 1) begin
               bus.cmd_valid               = 1'b1;
               bus.cmd_payload_function_id = {OP_CFG, 3'b000};
               bus.cmd_payload_inputs_1    = 32'd1;
            end
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_data", bus.rsp_payload_outputs_0, data);
            chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         end
         @(negedge clk);
         bus.rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
      chk("ready_back", 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic step(input string tag, input logic [6:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit early, input int stall,
                       output logic [31:0] got);
      logic [31:0] exp_v;
      int lat;
      exp_v = model_cmd(op, a, b);
      run_cmd(op, a, b, early, stall, got, lat);
      chk({tag, "_data"}, got, exp_v);
      chk({tag, "_lat"}, 32'(lat), (op == OP_RUN) ? 32'd2 : 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      int nl, nr;
      n_tests = 0;
      n_fail  = 0;
      bus.cmd_valid = 0; bus.cmd_payload_function_id = '0;
      bus.cmd_payload_inputs_0 = '0; bus.cmd_payload_inputs_1 = '0; bus.rsp_ready = 0;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("reset_rsp_data", bus.rsp_payload_outputs_0, 32'd0);

      // Basic sequence: two-word dot product, then restart
      step("cfg1", OP_CFG, 32'd128, 32'd2, 0, 0, got);
      step("load1", OP_LOAD, 32'h01010101, 32'd0, 0, 0, got);
      chk("load1_const", got, 32'd1);
      step("load2", OP_LOAD, 32'h02020202, 32'd0, 1, 0, got);
      chk("load2_const", got, 32'd2);
      step("run1", OP_RUN, 32'd0, 32'd0, 0, 0, got);
      chk("run1_const", got, 32'd512);
      step("run2", OP_RUN, 32'd0, 32'd0, 1, 0, got);
      chk("run2_const", got, 32'd1536);
      step("run3", OP_RUN, 32'd0, 32'd0, 0, 0, got);
      chk("run3_const", got, 32'd512);

      // Signed lane products
      step("cfg2", OP_CFG, 32'd0, 32'd1, 0, 0, got);
      step("load3", OP_LOAD, 32'hFF80017F, 32'd0, 0, 0, got);
      step("run_signed", OP_RUN, 32'h7F7F7F7F, 32'd0, 0, 0, got);
      chk("run_signed_const", got, 32'hFFFFFF81);

      // Buffer overflow
      step("cfg3", OP_CFG, 32'h1F3, 32'd0, 0, 0, got);
      for (int j = 0; j < 17; j++) step("fill", OP_LOAD, $urandom, $urandom, 0, 0, got);
      chk("fill17_const", got, 32'd16);
      step("stat_ovf", OP_STAT, $urandom, $urandom, 0, 0, got);
`ifdef MAC_SEQ_STATUS_EN
      chk("stat_ovf_const", got, 32'h80101000);
`else
      chk("stat_off_const", got, 32'd0);
`endif

      // Back-pressure on a RUN response with an ignored command pulse
      step("run_stall", OP_RUN, $urandom, 32'd0, 0, 5, got);
      step("run_after_stall", OP_RUN, $urandom, 32'd0, 0, 0, got);

      // Reset while in MUL
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_payload_function_id = {OP_RUN, 3'b000};
      bus.cmd_payload_inputs_0 = $urandom;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("midrst_rsp_valid2", 32'(bus.rsp_valid), 32'd0);
      step("midrst_stat", OP_STAT, 32'd0, 32'd0, 0, 0, got);
`ifdef MAC_SEQ_STATUS_EN
      chk("midrst_stat_const", got, 32'h40100000);
`endif

      // Unknown opcode leaves the run undisturbed
      step("cfg4", OP_CFG, $urandom, 32'd2, 0, 0, got);
      step("load4", OP_LOAD, $urandom, 32'd0, 0, 0, got);
      step("load5", OP_LOAD, $urandom, 32'd0, 0, 0, got);
      step("run4", OP_RUN, $urandom, 32'd0, 0, 0, got);
      step("op5", 7'd5, $urandom, $urandom, 0, 0, got);
      chk("op5_const", got, 32'd0);
      step("run5", OP_RUN, $urandom, 32'd0, 0, 0, got);

      // Randomized configurations and runs
      for (int it = 0; it < 12; it++) begin
         step("r_cfg", OP_CFG, $urandom, 32'($urandom_range(0, 31)), bit'($urandom_range(0, 1)), 0, got);
         nl = m_n + int'($urandom_range(0, 2));
         for (int j = 0; j < nl; j++)
            step("r_load", OP_LOAD, $urandom, $urandom, bit'($urandom_range(0, 1)), 0, got);
         nr = int'($urandom_range(1, 2 * m_n));
         for (int j = 0; j < nr; j++)
            step("r_run", OP_RUN, $urandom, $urandom, bit'($urandom_range(0, 1)), 0, got);
         if (it % 3 == 0)
            step("r_stat", OP_STAT, $urandom, $urandom, 0, 0, got);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
